// File: rtl/smem_port_ctrl.sv
// Valid/ready front-end for a single-port block RAM with a 1-cycle registered read.
// Define SMEM_INIT_CLEAR_EN to clear the whole RAM to INIT_VAL after reset.
module smem_port_ctrl #(
  parameter int                DWIDTH   = 32,
  parameter int                AWIDTH   = 11,
  parameter int                SIZE     = 2048,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              init_done,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic              mem_wr,
  input  logic [DWIDTH-1:0] mem_dout
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [DWIDTH-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;
  logic              rd_pend_q;
  logic [AWIDTH-1:0] addr_q;
  logic [1:0]        credit;
  logic              run, pop, push, accept;

  assign run       = (state_q == S_RUN);
  assign init_done = run;
  assign credit    = count_q + {1'b0, rd_pend_q};
  assign rsp_valid = (count_q != 2'd0);
  assign rsp_rdata = fifo_q[rd_ptr_q];
  assign pop       = rsp_valid && rsp_ready;
  // RAM dout is only meaningful the cycle after a read was issued.
  assign push      = rd_pend_q;
  // A pop in this cycle frees a slot, so ready may depend on rsp_ready.
  assign req_ready = run && ((credit < 2'd2) || pop);
  assign accept    = req_valid && req_ready;

`ifdef SMEM_INIT_CLEAR_EN
  logic [AWIDTH-1:0] init_cnt_q, init_cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == S_INIT) begin
      if (init_cnt_q == AWIDTH'(SIZE - 1)) state_d = S_RUN;
      else                                  init_cnt_d = init_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) init_cnt_q <= '0;
    else     init_cnt_q <= init_cnt_d;
  end
`else
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    if (state_q == S_INIT) state_d = S_RUN;
  end
`endif

  always_comb begin
    mem_addr = addr_q;
    mem_din  = req_wdata;
    mem_wr   = 1'b0;
    if (accept) begin
      mem_addr = req_addr;
      mem_wr   = req_wr;
    end
`ifdef SMEM_INIT_CLEAR_EN
    // Clear writes stay off while rst is held; the first one lands on the first edge after release.
    if (state_q == S_INIT) begin
      mem_addr = init_cnt_q;
      mem_din  = INIT_VAL;
      mem_wr   = !rst;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      addr_q    <= '0;
      // NOTE: the two FIFO words are plain flops, reset so rsp_rdata reads 0 out of reset.
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= accept && !req_wr;
      if (accept) addr_q <= req_addr;
      if (push) begin
        fifo_q[wr_ptr_q] <= mem_dout;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
